// File: rtl/par8_bus_if.sv
// Front end for the 8-bit parallel bus: synchronises the master's strobe, direction and data
// into clk_100mhz and bridges them to rx/tx byte streams. Define PAR8_RX_FIFO_EN for an 8-deep rx FIFO.
module par8_bus_if #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TURN_CYCLES = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk_100mhz,
   input  logic             reset_n,
   input  logic             bus_clk,
   input  logic             bus_rnw,
   input  logic [7:0]       bus_data_in,
   output logic [7:0]       bus_data_out,
   output logic             bus_data_oe,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [CNT_W-1:0] rx_count,
   output logic [CNT_W-1:0] tx_count,
   output logic [2:0]       err_flags
);

   localparam int unsigned TurnW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

   typedef enum logic [1:0] {StDirIn, StTurn, StDirOut} dir_state_e;

   logic [SYNC_STAGES-1:0]      clk_sync_q;
   logic [SYNC_STAGES-1:0]      rnw_sync_q;
   logic [SYNC_STAGES-1:0][7:0] data_sync_q;
   logic                        clk_s;
   logic                        rnw_s;
   logic [7:0]                  data_s;
   logic                        clk_prev_q;
   logic                        strobe_q;

   dir_state_e                  state_q, state_d;
   logic [TurnW-1:0]            turn_cnt_q, turn_cnt_d;

   logic                        wr_stb;
   logic                        rd_stb;
   logic                        turn_stb;

   logic                        rx_push;
   logic                        rx_pop;
   logic                        rx_ovr;
   logic [CNT_W-1:0]            rx_count_q;

   logic                        tx_full_q, tx_full_d;
   logic                        tx_ready_q;
   logic                        tx_load;
   logic                        tx_unf;
   logic [7:0]                  tx_data_q, tx_data_d;
   logic [CNT_W-1:0]            tx_count_q, tx_count_d;

   logic [2:0]                  err_q;

   // ---------------------------------------------------------------------------------------
   // Synchronisers and strobe detection
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync_q  <= '0;
         rnw_sync_q  <= '0;
         data_sync_q <= '0;
         clk_prev_q  <= 1'b0;
         strobe_q    <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus_clk};
         rnw_sync_q  <= {rnw_sync_q[SYNC_STAGES-2:0], bus_rnw};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus_data_in};
         clk_prev_q  <= clk_s;
         strobe_q    <= clk_s & ~clk_prev_q;
      end
   end

   assign clk_s  = clk_sync_q[SYNC_STAGES-1];
   assign rnw_s  = rnw_sync_q[SYNC_STAGES-1];
   assign data_s = data_sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------------------------------
   // Direction FSM
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StDirIn;
         turn_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         turn_cnt_q <= turn_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      turn_cnt_d = turn_cnt_q;
      unique case (state_q)
         StDirIn: begin
            if (rnw_s) begin
               state_d    = StTurn;
               turn_cnt_d = TurnW'(TURN_CYCLES - 1);
            end
         end
         StTurn: begin
            if (!rnw_s) begin
               state_d = StDirIn;
            end else if (turn_cnt_q == '0) begin
               state_d = StDirOut;
            end else begin
               turn_cnt_d = turn_cnt_q - TurnW'(1);
            end
         end
         StDirOut: begin
            if (!rnw_s) state_d = StDirIn;
         end
         default: state_d = StDirIn;
      endcase
   end

   // Driven from the next state so the pins turn on/off in the same cycle the decision is made.
   assign bus_data_oe = (state_d == StDirOut);

   assign wr_stb   = strobe_q & (state_q == StDirIn);
   assign rd_stb   = strobe_q & (state_q == StDirOut);
   assign turn_stb = strobe_q & (state_q == StTurn);

   // ---------------------------------------------------------------------------------------
   // Receive path
   // ---------------------------------------------------------------------------------------
`ifdef PAR8_RX_FIFO_EN
   logic [7:0][7:0] fifo_q;
   logic [2:0]      rd_ptr_q;
   logic [2:0]      wr_ptr_q;
   logic [3:0]      fill_q;

   assign rx_valid = (fill_q != 4'd0);
   assign rx_data  = fifo_q[rd_ptr_q];
   assign rx_pop   = rx_valid & rx_ready;
   // A pop on a full FIFO frees the slot the incoming byte is written into.
   assign rx_push  = wr_stb & ((fill_q != 4'd8) | rx_pop);
   assign rx_ovr   = wr_stb & ~rx_push;

   always_ff @(posedge clk_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         fifo_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         if (rx_push) begin
            fifo_q[wr_ptr_q] <= data_s;
            wr_ptr_q         <= wr_ptr_q + 3'd1;
         end
         if (rx_pop) rd_ptr_q <= rd_ptr_q + 3'd1;
         if (rx_push && !rx_pop) begin
            fill_q <= fill_q + 4'd1;
         end else if (!rx_push && rx_pop) begin
            fill_q <= fill_q - 4'd1;
         end
      end
   end
`else
   logic [7:0] rx_data_q;
   logic       rx_valid_q;

   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;
   assign rx_pop   = rx_valid_q & rx_ready;
   assign rx_push  = wr_stb & (~rx_valid_q | rx_ready);
   assign rx_ovr   = wr_stb & ~rx_push;

   always_ff @(posedge clk_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else if (rx_push) begin
         rx_data_q  <= data_s;
         rx_valid_q <= 1'b1;
      end else if (rx_pop) begin
         rx_valid_q <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clk_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         rx_count_q <= '0;
      end else if (rx_push) begin
         rx_count_q <= rx_count_q + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------------------
   // Transmit path
   // ---------------------------------------------------------------------------------------
   assign tx_load = tx_valid & tx_ready_q;

   always_comb begin
      tx_full_d  = tx_full_q;
      tx_data_d  = tx_data_q;
      tx_count_d = tx_count_q;
      tx_unf     = 1'b0;
      if (rd_stb) begin
         if (tx_full_q) begin
            tx_full_d  = 1'b0;
            tx_count_d = tx_count_q + CNT_W'(1);
         end else begin
            tx_unf = 1'b1;
         end
      end
      // Only possible while empty, so it never collides with a consumed byte.
      if (tx_load) begin
         tx_data_d = tx_data;
         tx_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         tx_full_q  <= 1'b0;
         tx_ready_q <= 1'b0;
         tx_data_q  <= '0;
         tx_count_q <= '0;
      end else begin
         tx_full_q  <= tx_full_d;
         tx_ready_q <= ~tx_full_d;
         tx_data_q  <= tx_data_d;
         tx_count_q <= tx_count_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Sticky error flags
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= '0;
      end else begin
         err_q <= err_q | {turn_stb, tx_unf, rx_ovr};
      end
   end

   assign bus_data_out = tx_data_q;
   assign tx_ready     = tx_ready_q;
   assign rx_count     = rx_count_q;
   assign tx_count     = tx_count_q;
   assign err_flags    = err_q;

endmodule

// File: tb/tb_par8_bus_if.sv
// Directed bench for par8_bus_if: rx bytes are checked by a scoreboard monitor, direction
// timing, counters and error flags by directed checks.
module tb_par8_bus_if;

   localparam int unsigned SS    = 2;
   localparam int unsigned TC    = 4;
   localparam int unsigned CNT_W = 16;

   logic             clk;
   logic             reset_n;
   logic             bus_clk;
   logic             bus_rnw;
   logic [7:0]       bus_data_in;
   logic [7:0]       bus_data_out;
   logic             bus_data_oe;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [CNT_W-1:0] rx_count;
   logic [CNT_W-1:0] tx_count;
   logic [2:0]       err_flags;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   par8_bus_if #(
      .SYNC_STAGES (SS),
      .TURN_CYCLES (TC),
      .CNT_W       (CNT_W)
   ) dut (
      .clk_100mhz   (clk),
      .reset_n      (reset_n),
      .bus_clk      (bus_clk),
      .bus_rnw      (bus_rnw),
      .bus_data_in  (bus_data_in),
      .bus_data_out (bus_data_out),
      .bus_data_oe  (bus_data_oe),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .rx_count     (rx_count),
      .tx_count     (tx_count),
      .err_flags    (err_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic master_strobe();
      bus_clk = 1'b1;
      tick(SS + 3);
      bus_clk = 1'b0;
      tick(SS + 2);
   endtask

   task automatic bus_write(input logic [7:0] b, input bit kept);
      bus_data_in = b;
      tick(1);
      if (kept) exp_q.push_back(b);
      master_strobe();
   endtask

   // Scoreboard monitor: every rx handshake must match the oldest expected byte.
   always @(negedge clk) begin
      if (reset_n && rx_valid && rx_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_unexpected: got %0h expected none", rx_data);
         end else begin
            chk("rx_data", {56'd0, rx_data}, {56'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      reset_n     = 1'b0;
      bus_clk     = 1'b0;
      bus_rnw     = 1'b0;
      bus_data_in = 8'h00;
      rx_ready    = 1'b0;
      tx_data     = 8'h00;
      tx_valid    = 1'b0;

      // Reset: every output low while held.
      #12;
      chk("reset_outputs", {10'd0, bus_data_out, bus_data_oe, rx_data, rx_valid, tx_ready,
                            rx_count, tx_count, err_flags}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick(3);
      chk("idle_oe", {63'd0, bus_data_oe}, 64'd0);
      chk("idle_tx_ready", {63'd0, tx_ready}, 64'd1);
      chk("idle_rx_valid", {63'd0, rx_valid}, 64'd0);

      // Single write with the core ready: latency and one-cycle valid.
      rx_ready    = 1'b1;
      bus_data_in = 8'hA5;
      tick(1);
      exp_q.push_back(8'hA5);
      bus_clk = 1'b1;
      for (int k = 1; k <= int'(SS) + 3; k++) begin
         tick(1);
         if (k == int'(SS) + 1) chk("rx_lat_early", {63'd0, rx_valid}, 64'd0);
         if (k == int'(SS) + 2) chk("rx_lat_valid", {63'd0, rx_valid}, 64'd1);
         if (k == int'(SS) + 3) chk("rx_one_cycle", {63'd0, rx_valid}, 64'd0);
      end
      bus_clk = 1'b0;
      tick(SS + 2);
      chk("rx_count_1", {48'd0, rx_count}, 64'd1);

      // Back-pressure: core not ready while the master keeps writing.
      rx_ready = 1'b0;
`ifdef PAR8_RX_FIFO_EN
      bus_write(8'h11, 1'b1);
      bus_write(8'h22, 1'b1);
      chk("fifo_no_ovr", {63'd0, err_flags[0]}, 64'd0);
      for (int i = 0; i < 7; i++) bus_write(8'h30 + 8'(i), i < 6);
      chk("rx_overrun", {63'd0, err_flags[0]}, 64'd1);
      chk("rx_count_ovr", {48'd0, rx_count}, 64'd9);
`else
      bus_write(8'h11, 1'b1);
      bus_write(8'h22, 1'b0);
      chk("rx_head_kept", {56'd0, rx_data}, 64'h11);
      chk("rx_overrun", {63'd0, err_flags[0]}, 64'd1);
      chk("rx_count_ovr", {48'd0, rx_count}, 64'd2);
`endif
      rx_ready = 1'b1;
      tick(12);
      chk("rx_drained", {63'd0, rx_valid}, 64'd0);

      // Preload a tx byte, then turn the bus around.
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      chk("tx_full_ready", {63'd0, tx_ready}, 64'd0);
      chk("tx_preload", {56'd0, bus_data_out}, 64'h3C);
      bus_rnw = 1'b1;
      for (int k = 1; k <= int'(TC + SS); k++) begin
         tick(1);
         if (k == int'(TC + SS) - 1) chk("oe_early", {63'd0, bus_data_oe}, 64'd0);
         if (k == int'(TC + SS)) chk("oe_on_time", {63'd0, bus_data_oe}, 64'd1);
      end
      tick(1);
      chk("read_data", {56'd0, bus_data_out}, 64'h3C);
      master_strobe();
      chk("tx_consumed_ready", {63'd0, tx_ready}, 64'd1);
      chk("tx_count_1", {48'd0, tx_count}, 64'd1);
      chk("no_underrun_yet", {63'd0, err_flags[1]}, 64'd0);
      master_strobe();
      chk("tx_underrun", {63'd0, err_flags[1]}, 64'd1);
      chk("tx_count_hold", {48'd0, tx_count}, 64'd1);
      chk("out_hold", {56'd0, bus_data_out}, 64'h3C);

      // Release the bus, then strobe while turning around again.
      bus_rnw = 1'b0;
      tick(SS + 2);
      chk("oe_off", {63'd0, bus_data_oe}, 64'd0);
      bus_rnw = 1'b1;
      for (int k = 1; k <= int'(TC + SS); k++) begin
         tick(1);
         if (k == 1) bus_clk = 1'b1;
         if (k == int'(TC + SS) - 1) chk("turn_oe_early", {63'd0, bus_data_oe}, 64'd0);
         if (k == int'(TC + SS)) chk("turn_oe_on_time", {63'd0, bus_data_oe}, 64'd1);
      end
      bus_clk = 1'b0;
      tick(SS + 2);
      chk("protocol_err", {63'd0, err_flags[2]}, 64'd1);
      chk("turn_tx_count", {48'd0, tx_count}, 64'd1);
`ifdef PAR8_RX_FIFO_EN
      chk("turn_rx_count", {48'd0, rx_count}, 64'd9);
`else
      chk("turn_rx_count", {48'd0, rx_count}, 64'd2);
`endif

      // Asynchronous reset while driving with a byte pending.
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      chk("pend_full", {63'd0, tx_ready}, 64'd0);
      chk("pend_oe", {63'd0, bus_data_oe}, 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_oe", {63'd0, bus_data_oe}, 64'd0);
      chk("async_out", {56'd0, bus_data_out}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick(1);
      chk("post_tx_ready", {63'd0, tx_ready}, 64'd1);
      chk("post_counts", {32'd0, rx_count, tx_count}, 64'd0);
      chk("post_err", {61'd0, err_flags}, 64'd0);
      chk("post_rx_valid", {63'd0, rx_valid}, 64'd0);

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
